// File: rtl/hpq_slice_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hpq_slice_ctrl_pkg
//  Description : Shared derivations for the hpq_slice query sequencer
//                (centroid sweep length, scan depth, address width and slice
//                result latency). These must stay in step with hpq_slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package hpq_slice_ctrl_pkg;

    // Width of the FSM state register
    localparam int c_STATE_W = 3;

    function automatic int hpq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Number of centroid sweep steps in phase 1
    function automatic int hpq_nc(input int kt, input int pt);
        return kt / pt;
    endfunction

    // Number of Yt offsets scanned in phase 2
    function automatic int hpq_vd(input int alpha, input int betta, input int ph);
        return (alpha * betta) / ph;
    endfunction

    // Centroid address width; a single-entry sweep still needs one address bit
    function automatic int hpq_aw(input int nc);
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

    // Cycles from the last offset to a valid slice minimum index
    function automatic int hpq_res_lat(input int m, input int ph);
        return 5 + $clog2(m) + $clog2(ph);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpq_slice_ctrl_delayline.sv
`default_nettype none
// ============================================================================
//  Module      : hpq_slice_ctrl_delayline
//  Description : Fixed-length enable-gated shift register used to align the
//                centroid issue with the distance RAM write. Reset flushes
//                every stage so no stale write can emerge after a reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpq_slice_ctrl_delayline #(
    parameter int W = 1,
    parameter int L = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] r_pipe [L];

    // Shift the pipe one stage per enabled cycle; reset empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (ena) begin
            r_pipe[0] <= din;
            for (int i = 1; i < L; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[L-1];

endmodule
`default_nettype wire

// File: rtl/hpq_slice_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hpq_slice_ctrl
//  Description : Query sequencer for hpq_slice. Latches a query and its cell,
//                sweeps centroid addresses (phase 1) with aligned distance RAM
//                writes, sweeps Yt offsets (phase 2), waits out the slice
//                pipeline and captures the minimum index.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpq_slice_ctrl
    import hpq_slice_ctrl_pkg::*;
#(
    parameter int D       = 32,
    parameter int W       = 32,
    parameter int M       = 8,
    parameter int ALPHA   = 32,
    parameter int BETTA   = 1,
    parameter int KT      = 32,
    parameter int PT      = 16,
    parameter int PH      = 8,
    parameter int CB_LAT  = 4,
    parameter int RES_LAT = hpq_res_lat(M, PH),
    parameter int NC      = hpq_nc(KT, PT),
    parameter int VD      = hpq_vd(ALPHA, BETTA, PH),
    parameter int AW      = hpq_aw(NC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            start,
    input  logic [W*D-1:0]  x_in,
    input  logic [31:0]     cell_in,
    output logic            busy,
    output logic            done,
    output logic [31:0]     res_idx,
    output logic [W*D-1:0]  x,
    output logic [31:0]     cell_sel,
    output logic [AW-1:0]   cb_cent_addr,
    output logic            cb_dist_wena,
    output logic [AW-1:0]   cb_dist_addr,
    output logic [31:0]     offset,
    input  logic [31:0]     slice_minidx
);

    // Sweep counter covers the longer of the two sweeps; drain counter the longer wait
    localparam int c_CW = $clog2(hpq_max(NC, VD)) + 1;
    localparam int c_DW = $clog2(hpq_max(hpq_max(CB_LAT, RES_LAT), 2)) + 1;

    localparam logic [c_CW-1:0] c_NC_LAST  = c_CW'(NC - 1);
    localparam logic [c_CW-1:0] c_VD_LAST  = c_CW'(VD - 1);
    localparam logic [c_DW-1:0] c_CB_LAST  = c_DW'((CB_LAT > 0) ? CB_LAT - 1 : 0);
    localparam logic [c_DW-1:0] c_RES_LAST = c_DW'(RES_LAT - 1);

    localparam logic [c_STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] S_P1_CENT  = 3'd1;
    localparam logic [c_STATE_W-1:0] S_P1_DRAIN = 3'd2;
    localparam logic [c_STATE_W-1:0] S_P2_SCAN  = 3'd3;
    localparam logic [c_STATE_W-1:0] S_P2_DRAIN = 3'd4;
    localparam logic [c_STATE_W-1:0] S_DONE     = 3'd5;

    logic [c_STATE_W-1:0] r_state, w_state_nxt;
    logic [c_CW-1:0]      r_cnt, w_cnt_nxt;
    logic [c_DW-1:0]      r_dcnt, w_dcnt_nxt;

    logic                 w_accept;
    logic                 w_cent_vld;
    logic [AW-1:0]        w_cent_addr;
    logic [31:0]          w_offset;
    logic                 w_busy;
    logic                 w_done;

    logic                 r_cent_vld;
    logic [AW-1:0]        r_cent_addr;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          r_res_idx;
    logic [W*D-1:0]       r_x;
    logic [31:0]          r_cell_sel;
    logic [31:0]          r_offset;
    logic [AW:0]          w_dly_out;

    assign w_accept = (r_state == S_IDLE) && start;

    // State and counter registers; everything freezes while ena is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state and counter sequencing; each phase exit clears its counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_P1_CENT;
                    w_cnt_nxt   = '0;
                end
            end
            S_P1_CENT: begin
                if (r_cnt == c_NC_LAST) begin
                    w_state_nxt = (CB_LAT == 0) ? S_P2_SCAN : S_P1_DRAIN;
                    w_cnt_nxt   = '0;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_P1_DRAIN: begin
                if (r_dcnt == c_CB_LAST) begin
                    w_state_nxt = S_P2_SCAN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_DW'(1);
                end
            end
            S_P2_SCAN: begin
                if (r_cnt == c_VD_LAST) begin
                    w_state_nxt = S_P2_DRAIN;
                    w_cnt_nxt   = '0;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_P2_DRAIN: begin
                if (r_dcnt == c_RES_LAST) begin
                    w_state_nxt = S_DONE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_DW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next output values decoded from the current state; cent address holds outside phase 1
    always_comb begin
        w_cent_vld  = (r_state == S_P1_CENT);
        w_cent_addr = w_cent_vld ? r_cnt[AW-1:0] : r_cent_addr;
        w_offset    = (r_state == S_P2_SCAN) ? 32'(r_cnt) : 32'd0;
        w_busy      = w_accept ||
                      (r_state == S_P1_CENT)  || (r_state == S_P1_DRAIN) ||
                      (r_state == S_P2_SCAN)  || (r_state == S_P2_DRAIN);
        w_done      = (r_state == S_DONE);
    end

    // Registered outputs plus query/cell latch on accept and result capture in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cent_vld  <= 1'b0;
            r_cent_addr <= '0;
            r_offset    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_idx   <= '0;
            r_x         <= '0;
            r_cell_sel  <= '0;
        end else if (ena) begin
            r_cent_vld  <= w_cent_vld;
            r_cent_addr <= w_cent_addr;
            r_offset    <= w_offset;
            r_busy      <= w_busy;
            r_done      <= w_done;
            if (w_accept) begin
                r_x        <= x_in;
                r_cell_sel <= cell_in;
            end
            if (w_done) begin
                r_res_idx <= slice_minidx;
            end
        end
    end

    // Distance write trails the centroid issue by CB_LAT enabled cycles
    generate
        if (CB_LAT > 0) begin : g_dly
            hpq_slice_ctrl_delayline #(
                .W (AW + 1),
                .L (CB_LAT)
            ) u_dly (
                .clk  (clk),
                .rst  (rst),
                .ena  (ena),
                .din  ({r_cent_vld, r_cent_addr}),
                .dout (w_dly_out)
            );
        end else begin : g_nodly
            assign w_dly_out = {r_cent_vld, r_cent_addr};
        end
    endgenerate

    assign cb_dist_wena = w_dly_out[AW];
    assign cb_dist_addr = w_dly_out[AW-1:0];
    assign cb_cent_addr = r_cent_addr;
    assign offset       = r_offset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign res_idx      = r_res_idx;
    assign x            = r_x;
    assign cell_sel     = r_cell_sel;

endmodule
`default_nettype wire

// File: tb/tb_hpq_slice_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpq_slice_ctrl
//  Description : Directed bench for hpq_slice_ctrl at default parameters and
//                at a single-centroid, zero-latency configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpq_slice_ctrl;

    localparam int XW = 1024;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    // Default-parameter instance
    logic            start0;
    logic [XW-1:0]   x_in0;
    logic [31:0]     cell_in0;
    logic [31:0]     slice_minidx0;
    logic            busy0, done0, wena0;
    logic [31:0]     res_idx0, cell_sel0, offset0;
    logic [XW-1:0]   x0;
    logic [0:0]      cent_addr0, dist_addr0;

    // NC=1, CB_LAT=0 instance
    logic            start1;
    logic [XW-1:0]   x_in1;
    logic [31:0]     cell_in1;
    logic [31:0]     slice_minidx1;
    logic            busy1, done1, wena1;
    logic [31:0]     res_idx1, cell_sel1, offset1;
    logic [XW-1:0]   x1;
    logic [0:0]      cent_addr1, dist_addr1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hpq_slice_ctrl u_dut0 (
        .clk(clk), .rst(rst), .ena(ena), .start(start0), .x_in(x_in0), .cell_in(cell_in0),
        .busy(busy0), .done(done0), .res_idx(res_idx0), .x(x0), .cell_sel(cell_sel0),
        .cb_cent_addr(cent_addr0), .cb_dist_wena(wena0), .cb_dist_addr(dist_addr0),
        .offset(offset0), .slice_minidx(slice_minidx0)
    );

    hpq_slice_ctrl #(.KT(16), .PT(16), .CB_LAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .start(start1), .x_in(x_in1), .cell_in(cell_in1),
        .busy(busy1), .done(done1), .res_idx(res_idx1), .x(x1), .cell_sel(cell_sel1),
        .cb_cent_addr(cent_addr1), .cb_dist_wena(wena1), .cb_dist_addr(dist_addr1),
        .offset(offset1), .slice_minidx(slice_minidx1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_vec++;
        if ({busy0, done0, wena0, cent_addr0, dist_addr0} !== 5'b0 || offset0 !== 32'd0 ||
            res_idx0 !== 32'd0 || cell_sel0 !== 32'd0 || x0 !== '0) begin
            n_err++;
            $display("FAIL reset_dut0 busy=%b done=%b wena=%b offset=%h res=%h cell=%h required all 0",
                     busy0, done0, wena0, offset0, res_idx0, cell_sel0);
        end
        n_vec++;
        if ({busy1, done1, wena1, cent_addr1, dist_addr1} !== 5'b0 || offset1 !== 32'd0 ||
            res_idx1 !== 32'd0 || cell_sel1 !== 32'd0 || x1 !== '0) begin
            n_err++;
            $display("FAIL reset_dut1 busy=%b done=%b wena=%b offset=%h res=%h cell=%h required all 0",
                     busy1, done1, wena1, offset1, res_idx1, cell_sel1);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [31:0] e_off;
        logic        e_wena;
        slice_minidx0 = 32'h1000;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            slice_minidx0 = 32'h1000 + 32'(k);
            n_vec++;
            if (cent_addr0 !== ((k >= 2) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL basic_cent k=%0d got=%0d exp=%0d", k, cent_addr0, (k >= 2));
            end
            e_wena = (k == 5 || k == 6);
            n_vec++;
            if (wena0 !== e_wena) begin
                n_err++;
                $display("FAIL basic_wena k=%0d got=%b exp=%b", k, wena0, e_wena);
            end
            if (e_wena) begin
                n_vec++;
                if (dist_addr0 !== ((k == 6) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL basic_daddr k=%0d got=%0d exp=%0d", k, dist_addr0, (k == 6));
                end
            end
            e_off = (k >= 7 && k <= 10) ? 32'(k - 7) : 32'd0;
            n_vec++;
            if (offset0 !== e_off) begin
                n_err++;
                $display("FAIL basic_offset k=%0d got=%0d exp=%0d", k, offset0, e_off);
            end
            n_vec++;
            if (done0 !== (k == 22) || busy0 !== (k < 22)) begin
                n_err++;
                $display("FAIL basic_done_busy k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done0, busy0, (k == 22), (k < 22));
            end
            if (k >= 22) begin
                n_vec++;
                if (res_idx0 !== 32'h1015) begin
                    n_err++;
                    $display("FAIL basic_res k=%0d got=%h exp=%h", k, res_idx0, 32'h1015);
                end
            end
        end
    endtask

    task automatic test_latch;
        logic [XW-1:0] xs;
        for (int i = 0; i < XW / 32; i++) begin
            xs[i*32 +: 32] = $urandom;
        end
        x_in0    = xs;
        cell_in0 = 32'd5;
        start0   = 1'b1;
        tick();
        start0   = 1'b0;
        x_in0    = ~xs;
        cell_in0 = 32'd9;
        for (int k = 1; k <= 22; k++) begin
            tick();
            n_vec++;
            if (cell_sel0 !== 32'd5 || x0 !== xs) begin
                n_err++;
                $display("FAIL latch k=%0d got cell=%0d x_ok=%b exp cell=5 x_ok=1", k, cell_sel0, (x0 === xs));
            end
        end
        n_vec++;
        if (done0 !== 1'b1) begin
            n_err++;
            $display("FAIL latch_done got=%b exp=1", done0);
        end
    endtask

    task automatic test_start_held;
        logic e_busy;
        start0 = 1'b1;
        tick();
        for (int k = 1; k <= 46; k++) begin
            tick();
            e_busy = (k <= 21) || (k >= 23 && k <= 44);
            n_vec++;
            if (done0 !== (k == 22 || k == 45) || busy0 !== e_busy) begin
                n_err++;
                $display("FAIL held k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done0, busy0, (k == 22 || k == 45), e_busy);
            end
            if (k == 45) start0 = 1'b0;
        end
    endtask

    task automatic test_ena_stall;
        logic [31:0] e_off;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            ena = !(k >= 8 && k <= 10);
            if (k >= 7 && k <= 14) begin
                case (k)
                    7:       e_off = 32'd0;
                    12:      e_off = 32'd2;
                    13:      e_off = 32'd3;
                    14:      e_off = 32'd0;
                    default: e_off = 32'd1;
                endcase
                n_vec++;
                if (offset0 !== e_off) begin
                    n_err++;
                    $display("FAIL stall_offset k=%0d got=%0d exp=%0d", k, offset0, e_off);
                end
            end
            if (k >= 21) begin
                n_vec++;
                if (done0 !== (k == 25)) begin
                    n_err++;
                    $display("FAIL stall_done k=%0d got=%b exp=%b", k, done0, (k == 25));
                end
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_rst_mid;
        x_in0    = {32{32'hA5C3_0F96}};
        cell_in0 = 32'd7;
        start0   = 1'b1;
        tick();
        start0   = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        n_vec++;
        if (wena0 !== 1'b1 || dist_addr0 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre got wena=%b addr=%0d exp wena=1 addr=1", wena0, dist_addr0);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy0, done0, wena0, cent_addr0, dist_addr0} !== 5'b0 || offset0 !== 32'd0 ||
            res_idx0 !== 32'd0 || cell_sel0 !== 32'd0 || x0 !== '0) begin
            n_err++;
            $display("FAIL rst_mid busy=%b done=%b wena=%b cent=%0d res=%h cell=%h required all 0",
                     busy0, done0, wena0, cent_addr0, res_idx0, cell_sel0);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++;
            if (wena0 !== 1'b0 || busy0 !== 1'b0) begin
                n_err++;
                $display("FAIL rst_after k=%0d got wena=%b busy=%b exp 0 0", k, wena0, busy0);
            end
        end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            n_vec++;
            if (done0 !== (k == 22) || wena0 !== (k == 5 || k == 6)) begin
                n_err++;
                $display("FAIL rst_rerun k=%0d got done=%b wena=%b exp done=%b wena=%b",
                         k, done0, wena0, (k == 22), (k == 5 || k == 6));
            end
        end
        n_vec++;
        if (cell_sel0 !== 32'd7) begin
            n_err++;
            $display("FAIL rst_rerun_cell got=%0d exp=7", cell_sel0);
        end
    endtask

    task automatic test_nc1;
        logic [31:0] e_off;
        slice_minidx1 = 32'h2000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            slice_minidx1 = 32'h2000 + 32'(k);
            n_vec++;
            if (cent_addr1 !== 1'b0 || wena1 !== (k == 1) || (k == 1 && dist_addr1 !== 1'b0)) begin
                n_err++;
                $display("FAIL nc1_cent k=%0d got cent=%0d wena=%b daddr=%0d exp cent=0 wena=%b daddr=0",
                         k, cent_addr1, wena1, dist_addr1, (k == 1));
            end
            e_off = (k >= 2 && k <= 5) ? 32'(k - 2) : 32'd0;
            n_vec++;
            if (offset1 !== e_off) begin
                n_err++;
                $display("FAIL nc1_offset k=%0d got=%0d exp=%0d", k, offset1, e_off);
            end
            n_vec++;
            if (done1 !== (k == 17) || busy1 !== (k < 17)) begin
                n_err++;
                $display("FAIL nc1_done_busy k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, done1, busy1, (k == 17), (k < 17));
            end
            if (k >= 17) begin
                n_vec++;
                if (res_idx1 !== 32'h2010) begin
                    n_err++;
                    $display("FAIL nc1_res k=%0d got=%h exp=%h", k, res_idx1, 32'h2010);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        start0 = 1'b0; x_in0 = '0; cell_in0 = '0; slice_minidx0 = '0;
        start1 = 1'b0; x_in1 = '0; cell_in1 = '0; slice_minidx1 = '0;
        test_reset();
        test_basic();
        tick();
        test_latch();
        tick();
        test_start_held();
        tick();
        test_ena_stall();
        tick();
        test_rst_mid();
        tick();
        test_nc1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
